// File: rtl/seq_gen_prog.sv
// seq_gen_prog: programmable serial bit-pattern generator, LSB first, repeat or one-shot.
// Define SEQ_GEN_PROG_CNT_EN to add the 8-bit pass_cnt output.
module seq_gen_prog #(
  parameter int MAX_LEN = 16,
  localparam int PTR_W = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [PTR_W-1:0]   length,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  input  logic               en,
`ifdef SEQ_GEN_PROG_CNT_EN
  output logic [7:0]         pass_cnt,
`endif
  output logic               out,
  output logic               valid,
  output logic               done,
  output logic               busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [PTR_W-1:0] LAST_MAX = PTR_W'(MAX_LEN - 1);
  state_t state, state_nx;
  logic [PTR_W-1:0] idx, idx_nx, len_q, len_nx, last;
  logic [MAX_LEN-1:0] pat_q, pat_nx;
  logic mode_q, mode_nx, out_nx, valid_nx, done_nx, go, wrap;
  // lengths beyond the pattern width only occur for non-power-of-2 MAX_LEN
  assign last = len_q > LAST_MAX ? LAST_MAX : len_q;
  assign go = state == IDLE && start && !stop;
  assign wrap = idx == last;
  assign busy = state == RUN;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    pat_nx = pat_q;
    len_nx = len_q;
    mode_nx = mode_q;
    out_nx = out;
    valid_nx = 1'b0;
    done_nx = 1'b0;
    if (state == IDLE) begin
      pat_nx = load ? pattern : pat_q;
      len_nx = load ? length : len_q;
      state_nx = go ? RUN : IDLE;
      idx_nx = '0;
      mode_nx = go ? mode : mode_q;
    end else if (stop) begin
      state_nx = IDLE;
      idx_nx = '0;
    end else if (en) begin
      out_nx = pat_q[idx];
      valid_nx = 1'b1;
      done_nx = wrap;
      idx_nx = wrap ? '0 : idx + 1'b1;
      state_nx = wrap && mode_q ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      pat_q <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      out <= 1'b0;
      valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      pat_q <= pat_nx;
      len_q <= len_nx;
      mode_q <= mode_nx;
      out <= out_nx;
      valid <= valid_nx;
      done <= done_nx;
    end
  end
`ifdef SEQ_GEN_PROG_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pass_cnt <= '0;
    else pass_cnt <= go ? 8'd0 : done_nx ? pass_cnt + 8'd1 : pass_cnt;
  end
`endif
endmodule

// File: tb/tb_seq_gen_prog.sv
// tb_seq_gen_prog: checks a 16-bit and a 12-bit generator side by side against a counting model.
module tb_seq_gen_prog;
  logic clk = 1'b0;
  logic rst, load, start, stop, en, mode;
  logic [15:0] pattern;
  logic [3:0] length;
  logic [1:0] out_v, valid_v, done_v, busy_v;
  int checks = 0, failures = 0;
  logic [15:0] got;
  int nb;
  bit m_busy[2], m_out[2], m_valid[2], m_done[2], m_one[2];
  int m_n[2], m_len[2], m_cnt[2];
  logic [15:0] m_pat[2];
  int maxl[2] = '{16, 12};
`ifdef SEQ_GEN_PROG_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif
  always #5 clk = ~clk;

  seq_gen_prog #(.MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern), .length(length),
    .mode(mode), .start(start), .stop(stop), .en(en),
`ifdef SEQ_GEN_PROG_CNT_EN
    .pass_cnt(cnt0),
`endif
    .out(out_v[0]), .valid(valid_v[0]), .done(done_v[0]), .busy(busy_v[0]));

  seq_gen_prog #(.MAX_LEN(12)) dut12 (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern[11:0]), .length(length),
    .mode(mode), .start(start), .stop(stop), .en(en),
`ifdef SEQ_GEN_PROG_CNT_EN
    .pass_cnt(cnt1),
`endif
    .out(out_v[1]), .valid(valid_v[1]), .done(done_v[1]), .busy(busy_v[1]));

  task automatic chk(string tag, int d, logic [31:0] got_v, logic [31:0] want);
    checks++;
    assert (got_v === want) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, got_v, want);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_out[d] = 0; m_valid[d] = 0; m_done[d] = 0; m_one[d] = 0;
      m_n[d] = 0; m_len[d] = 1; m_cnt[d] = 0; m_pat[d] = '0;
    end
  endtask

  // Bit n of a run (counting enabled cycles) is pattern[n mod L].
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!m_busy[d]) begin
        m_valid[d] = 0; m_done[d] = 0;
        if (load) begin
          m_pat[d] = pattern;
          m_len[d] = (int'(length) + 1 > maxl[d]) ? maxl[d] : int'(length) + 1;
        end
        if (start && !stop) begin
          m_busy[d] = 1; m_n[d] = 0; m_one[d] = mode; m_cnt[d] = 0;
        end
      end else if (stop || !en) begin
        if (stop) m_busy[d] = 0;
        m_valid[d] = 0; m_done[d] = 0;
      end else begin
        m_out[d] = m_pat[d][m_n[d] % m_len[d]];
        m_valid[d] = 1;
        m_done[d] = (m_n[d] % m_len[d]) == m_len[d] - 1;
        m_n[d]++;
        if (m_done[d]) m_cnt[d] = (m_cnt[d] + 1) % 256;
        if (m_done[d] && m_one[d]) m_busy[d] = 0;
      end
    end
  endtask

  task automatic chk_all();
    for (int d = 0; d < 2; d++) begin
      chk("out", d, out_v[d], m_out[d]);
      chk("valid", d, valid_v[d], m_valid[d]);
      chk("done", d, done_v[d], m_done[d]);
      chk("busy", d, busy_v[d], m_busy[d]);
    end
`ifdef SEQ_GEN_PROG_CNT_EN
    chk("pass_cnt", 0, cnt0, m_cnt[0]);
    chk("pass_cnt", 1, cnt1, m_cnt[1]);
`endif
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      chk_all();
      if (valid_v[0] && nb < 16) begin
        got[nb] = out_v[0];
        nb++;
      end
    end
  endtask

  task automatic go(logic [15:0] p, logic [3:0] l, logic m);
    load = 1; start = 1; pattern = p; length = l; mode = m; stop = 0;
    cyc();
    load = 0; start = 0;
    nb = 0; got = '0;
  endtask

  initial begin
    rst = 0; load = 0; start = 0; stop = 0; en = 1; mode = 0; pattern = '0; length = '0;
    nb = 0; got = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 1;
    // one-shot 11001 with load and start together
    go(16'h0013, 4'd4, 1'b1);
    chk("start_busy", 0, busy_v[0], 1);
    cyc(5);
    chk("oneshot_bits", 0, got[4:0], 5'h13);
    chk("oneshot_idle", 0, busy_v[0], 0);
    cyc(2);
    // repeat 1101, three gapless passes, then stop
    go(16'h000B, 4'd3, 1'b0);
    cyc(12);
    chk("repeat_bits", 0, got[11:0], 12'hBBB);
    stop = 1;
    cyc();
    chk("stop_valid", 0, valid_v[0], 0);
    stop = 0;
    // stall mid-pattern for 3 cycles
    go(16'h00A5, 4'd7, 1'b0);
    cyc(3);
    en = 0;
    cyc(3);
    en = 1;
    cyc(5);
    chk("stall_bits", 0, got[7:0], 8'hA5);
    // load while busy is ignored
    load = 1; pattern = 16'hFFFF; length = 4'd2;
    cyc(10);
    load = 0;
    stop = 1;
    cyc();
    stop = 0;
    // full length: 16 bits on dut, clamped to 12 on dut12
    go(16'h8F31, 4'd15, 1'b0);
    cyc(48);
    chk("len16_bits", 0, got, 16'h8F31);
    stop = 1;
    cyc();
    stop = 0;
    // L = 1: done every cycle, 300 passes
    go(16'h0001, 4'd0, 1'b0);
    cyc(300);
`ifdef SEQ_GEN_PROG_CNT_EN
    chk("cnt_wrap", 0, cnt0, 8'd44);
`endif
    stop = 1;
    cyc();
    stop = 0;
    go(16'h0006, 4'd2, 1'b0);
`ifdef SEQ_GEN_PROG_CNT_EN
    chk("cnt_clear", 0, cnt0, 8'd0);
`endif
    cyc(4);
    // asynchronous reset mid-run
    #2 rst = 0;
    #1;
    model_reset();
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    rst = 1;
    cyc();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      load = ($urandom % 4) == 0;
      start = ($urandom % 6) == 0;
      stop = ($urandom % 20) == 0;
      en = ($urandom % 4) != 0;
      mode = $urandom % 2;
      pattern = 16'($urandom);
      length = 4'($urandom);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
